dma_vector_writer: RTL and testbench

DMA_VECTOR_WRITER -- requirements
Module: dma_vector_writer

---
 rtl/dma_pkg.sv | 29 ++
 rtl/dma_wbuf.sv | 27 ++
 rtl/dma_vector_writer.sv | 194 +++++++++++++++++++
 tb/tb_dma_vector_writer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA vector writer: register map, CTRL/status bit positions,
// FSM encoding and the default buffer depth.
package dma_pkg;

    localparam int DEFAULT_MAX_LENGTH = 256;

    // Register word indices (byte address bits [7:2])
    localparam logic [5:0] REG_CTRL     = 6'h00;
    localparam logic [5:0] REG_LENGTH   = 6'h01;
    localparam logic [5:0] REG_ADDR     = 6'h02;
    localparam logic [5:0] REG_BUF_IDX  = 6'h03;
    localparam logic [5:0] REG_BUF_DATA = 6'h04;
    localparam logic [5:0] REG_SENT     = 6'h05;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLEAR_BIT = 1;
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_ERR_BIT   = 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREFETCH = 3'd1,
        S_ISSUE    = 3'd2,
        S_STREAM   = 3'd3,
        S_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/dma_wbuf.sv
// Word buffer for the DMA writer: simple dual-port RAM, CPU write port and a
// registered read port with one cycle of latency.
module dma_wbuf #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dma_vector_writer.sv
// CPU-loaded word buffer streamed to SDRAM as a single 32-bit burst.
// Optional feature: define DMA_WRITER_IRQ_EN to add an irq output that follows DONE.
module dma_vector_writer
    import dma_pkg::*;
#(
    parameter int MAX_LENGTH = DEFAULT_MAX_LENGTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_valid,
    input  logic        reg_write,
    input  logic [7:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_ready,
    output logic        burst_wr,
    output logic [24:0] burst_addr,
    output logic [10:0] burst_len,
    output logic        burst_32bit,
    output logic [31:0] burst_wdata,
    input  logic        burst_data_req,
    input  logic        burst_data_done
`ifdef DMA_WRITER_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int         AW      = $clog2(MAX_LENGTH);
    localparam logic [8:0] MAX_LEN = 9'(MAX_LENGTH);

    state_t      state_q, state_d;
    logic        pf_q, pf_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [8:0]  length_q, length_d;
    logic [8:0]  sent_q, sent_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  buf_idx_q, buf_idx_d;
    logic [31:0] head_q, head_d;
    logic        vld_prev_q;

    logic        busy;
    logic        wr_acc;
    logic        ram_we;
    logic [5:0]  widx;
    logic [8:0]  rd_ptr;
    logic [31:0] next_word;
    logic        unused_bits;

    assign busy      = (state_q != S_IDLE);
    assign widx      = reg_addr[7:2];
    // A held strobe acts only on its first cycle
    assign wr_acc    = reg_valid & reg_write & ~vld_prev_q & ~busy;
    assign ram_we    = wr_acc & (widx == REG_BUF_DATA);
    assign reg_ready = reg_valid;

    always_comb begin
        reg_rdata = '0;
        case (widx)
            REG_CTRL: begin
                reg_rdata[STAT_BUSY_BIT] = busy;
                reg_rdata[STAT_DONE_BIT] = done_q;
                reg_rdata[STAT_ERR_BIT]  = err_q;
            end
            REG_LENGTH:  reg_rdata[8:0]  = length_q;
            REG_ADDR:    reg_rdata[23:0] = addr_q;
            REG_BUF_IDX: reg_rdata[7:0]  = buf_idx_q;
            REG_SENT:    reg_rdata[8:0]  = sent_q;
            default:     reg_rdata       = '0;
        endcase
    end

    // The RAM output always holds the word after head, so a req every cycle never stalls
    assign rd_ptr = (state_q == S_PREFETCH) ? {8'd0, pf_q} : sent_d + 9'd1;

    dma_wbuf #(
        .DEPTH (MAX_LENGTH),
        .AW    (AW)
    ) u_wbuf (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (buf_idx_q[AW-1:0]),
        .wdata_i (reg_wdata),
        .raddr_i (rd_ptr[AW-1:0]),
        .rdata_o (next_word)
    );

    always_comb begin
        state_d   = state_q;
        pf_d      = pf_q;
        done_d    = done_q;
        err_d     = err_q;
        length_d  = length_q;
        sent_d    = sent_q;
        addr_d    = addr_q;
        buf_idx_d = buf_idx_q;
        head_d    = head_q;

        if (wr_acc) begin
            case (widx)
                REG_CTRL: begin
                    if (reg_wdata[CTRL_CLEAR_BIT]) begin
                        done_d = 1'b0;
                    end
                    if (reg_wdata[CTRL_START_BIT]) begin
                        if (length_q == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = S_PREFETCH;
                            pf_d    = 1'b0;
                            done_d  = 1'b0;
                            err_d   = 1'b0;
                            sent_d  = '0;
                        end
                    end
                end
                REG_LENGTH:   length_d  = (reg_wdata > 32'(MAX_LENGTH)) ? MAX_LEN : reg_wdata[8:0];
                REG_ADDR:     addr_d    = reg_wdata[23:0];
                REG_BUF_IDX:  buf_idx_d = reg_wdata[7:0];
                REG_BUF_DATA: buf_idx_d = buf_idx_q + 8'd1;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: ;
            S_PREFETCH: begin
                pf_d = 1'b1;
                if (pf_q) begin
                    head_d  = next_word;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_STREAM;
            S_STREAM: begin
                if (burst_data_req && (sent_q != length_q)) begin
                    sent_d = sent_q + 9'd1;
                    head_d = next_word;
                end
                if (burst_data_done) begin
                    err_d   = (sent_d != length_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pf_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            length_q   <= '0;
            sent_q     <= '0;
            addr_q     <= '0;
            buf_idx_q  <= '0;
            vld_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pf_q       <= pf_d;
            done_q     <= done_d;
            err_q      <= err_d;
            length_q   <= length_d;
            sent_q     <= sent_d;
            addr_q     <= addr_d;
            buf_idx_q  <= buf_idx_d;
            vld_prev_q <= reg_valid;
        end
    end

    always_ff @(posedge clk) begin
        head_q <= head_d;
    end

    assign burst_wr    = (state_q == S_ISSUE);
    assign burst_addr  = {addr_q, 1'b0};
    assign burst_len   = {1'b0, length_q, 1'b0};
    assign burst_32bit = 1'b1;
    assign burst_wdata = ((state_q == S_STREAM) && (sent_q != length_q)) ? head_q : '0;

`ifdef DMA_WRITER_IRQ_EN
    assign irq = done_q;
`endif

    assign unused_bits = ^{reg_addr[1:0], rd_ptr, buf_idx_q};

endmodule

// File: tb/tb_dma_vector_writer.sv
// Scoreboard bench for dma_vector_writer: directed scenarios plus randomized bursts
// checked against an array/queue model of the register and buffer behaviour.
module tb_dma_vector_writer;

    localparam logic [7:0] A_CTRL = 8'h00;
    localparam logic [7:0] A_LEN  = 8'h04;
    localparam logic [7:0] A_ADDR = 8'h08;
    localparam logic [7:0] A_IDX  = 8'h0C;
    localparam logic [7:0] A_DATA = 8'h10;
    localparam logic [7:0] A_SENT = 8'h14;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_valid, reg_write;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic        reg_ready;
    logic        burst_wr, burst_32bit;
    logic [24:0] burst_addr;
    logic [10:0] burst_len;
    logic [31:0] burst_wdata;
    logic        burst_data_req, burst_data_done;
`ifdef DMA_WRITER_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    dma_vector_writer #(.MAX_LENGTH(256)) dut (
        .clk             (clk),
        .reset           (reset),
        .reg_valid       (reg_valid),
        .reg_write       (reg_write),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_rdata       (reg_rdata),
        .reg_ready       (reg_ready),
        .burst_wr        (burst_wr),
        .burst_addr      (burst_addr),
        .burst_len       (burst_len),
        .burst_32bit     (burst_32bit),
        .burst_wdata     (burst_wdata),
        .burst_data_req  (burst_data_req),
        .burst_data_done (burst_data_done)
`ifdef DMA_WRITER_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    int tests = 0;
    int fails = 0;
    int burst_cnt = 0;

    logic [31:0] exp_word [$];
    logic [24:0] exp_baddr [$];
    logic [10:0] exp_blen [$];
    logic [31:0] exp_rd [$];
    string       exp_nm [$];

    // Reference model state
    logic [31:0] m_buf [256];
    int          m_len, m_idx, m_sent;
    logic [23:0] m_addr;
    bit          m_done, m_err;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_exp();
        return {29'b0, m_err, m_done, 1'b0};
    endfunction

    always @(negedge clk) begin
        logic [31:0] e;
        string       n;
        if (burst_wr === 1'b1) begin
            burst_cnt++;
            if (exp_baddr.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_burst_wr: got burst_wr=1 addr=0x%07h, required no burst", burst_addr);
            end else begin
                check("burst_addr", 32'(burst_addr), 32'(exp_baddr.pop_front()));
                check("burst_len", 32'(burst_len), 32'(exp_blen.pop_front()));
                check("burst_32bit", 32'(burst_32bit), 32'd1);
            end
        end
        if (burst_data_req === 1'b1) begin
            if (exp_word.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_req: got wdata 0x%08h, required no req", burst_wdata);
            end else begin
                check("burst_wdata", burst_wdata, exp_word.pop_front());
            end
        end
        if (reg_valid === 1'b1 && reg_write === 1'b0) begin
            if (exp_rd.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_read: got 0x%08h, required no read", reg_rdata);
            end else begin
                e = exp_rd.pop_front();
                n = exp_nm.pop_front();
                check(n, reg_rdata, e);
                check("reg_ready", 32'(reg_ready), 32'd1);
`ifdef DMA_WRITER_IRQ_EN
                if (reg_addr == A_CTRL) check("irq", 32'(irq), {31'b0, e[1]});
`endif
            end
        end
    end

    task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        reg_valid = 1'b1; reg_write = 1'b1; reg_addr = a; reg_wdata = d;
        @(posedge clk); #1;
        reg_valid = 1'b0; reg_write = 1'b0;
    endtask

    task automatic rd_check(input logic [7:0] a, input logic [31:0] exp, input string nm);
        exp_rd.push_back(exp);
        exp_nm.push_back(nm);
        @(posedge clk); #1;
        reg_valid = 1'b1; reg_write = 1'b0; reg_addr = a;
        @(posedge clk); #1;
        reg_valid = 1'b0;
    endtask

    // Register write that also updates the model (only used while the model is idle)
    task automatic mwr(input logic [7:0] a, input logic [31:0] d);
        reg_wr(a, d);
        case (a)
            A_CTRL: begin
                if (d[1]) m_done = 1'b0;
                if (d[0] && m_len == 0) m_done = 1'b1;
            end
            A_LEN:  m_len = (d > 32'd256) ? 256 : int'(d);
            A_ADDR: m_addr = d[23:0];
            A_IDX:  m_idx = int'(d[7:0]);
            A_DATA: begin
                m_buf[m_idx] = d;
                m_idx = (m_idx + 1) % 256;
            end
            default: ;
        endcase
    endtask

    task automatic wait_burst(input int base, output bit ok);
        int waited = 0;
        while (burst_cnt == base && waited < 64) begin
            @(posedge clk); #1;
            waited++;
        end
        ok = (burst_cnt != base);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL burst_wr_timeout: got no burst_wr in %0d cycles, required one", waited);
            exp_baddr.delete();
            exp_blen.delete();
        end
    endtask

    // mode 0: req every cycle, 1: alternating cycles, 2: random gaps
    task automatic run_dma(input int n_req, input int mode, input bit poke);
        int base, k, cyc;
        bit ok, fire;
        exp_baddr.push_back({m_addr, 1'b0});
        exp_blen.push_back(11'(m_len * 2));
        base = burst_cnt;
        reg_wr(A_CTRL, 32'h1);
        m_sent = 0; m_err = 1'b0; m_done = 1'b0;
        if (poke) reg_wr(A_ADDR, 32'h00ABCDEF);
        wait_burst(base, ok);
        if (!ok) return;
        k = 0;
        cyc = 0;
        while (k < n_req) begin
            @(posedge clk); #1;
            case (mode)
                0:       fire = 1'b1;
                1:       fire = (cyc % 2 == 0);
                default: fire = ($urandom_range(0, 1) == 1);
            endcase
            cyc++;
            burst_data_req = fire;
            if (fire) begin
                exp_word.push_back((k < m_len) ? m_buf[k] : 32'h0);
                k++;
            end
        end
        @(posedge clk); #1;
        burst_data_req = 1'b0;
        burst_data_done = 1'b1;
        @(posedge clk); #1;
        burst_data_done = 1'b0;
        @(posedge clk); #1;
        m_sent = (n_req < m_len) ? n_req : m_len;
        m_err  = (m_sent != m_len);
        m_done = 1'b1;
        rd_check(A_CTRL, ctrl_exp(), "ctrl_after_burst");
        rd_check(A_SENT, 32'(m_sent), "sent_after_burst");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500us, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, nr, mode, base;
        bit ok;
        reset = 1'b1;
        reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0;
        burst_data_req = 1'b0; burst_data_done = 1'b0;
        m_len = 0; m_idx = 0; m_sent = 0; m_addr = '0; m_done = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 256; i++) m_buf[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_burst_wr", 32'(burst_wr), 32'd0);
        check("rst_burst_addr", 32'(burst_addr), 32'd0);
        check("rst_burst_len", 32'(burst_len), 32'd0);
        check("rst_burst_wdata", burst_wdata, 32'd0);
        reset = 1'b0;
        rd_check(A_CTRL, 32'h0, "rst_ctrl");
        rd_check(A_LEN, 32'h0, "rst_len");
        rd_check(A_ADDR, 32'h0, "rst_addr");
        rd_check(A_IDX, 32'h0, "rst_idx");
        rd_check(A_SENT, 32'h0, "rst_sent");

        // Basic four-word burst, back-to-back then alternating requests
        mwr(A_IDX, 32'h0);
        mwr(A_DATA, 32'h11); mwr(A_DATA, 32'h22); mwr(A_DATA, 32'h33); mwr(A_DATA, 32'h44);
        rd_check(A_IDX, 32'h4, "idx_after_load");
        mwr(A_LEN, 32'd4);
        mwr(A_ADDR, 32'h000100);
        run_dma(4, 0, 1'b0);
        run_dma(4, 1, 1'b0);

        // Zero-length start completes without a burst
        mwr(A_CTRL, 32'h2);
        rd_check(A_CTRL, ctrl_exp(), "ctrl_cleared");
        mwr(A_LEN, 32'd0);
        mwr(A_CTRL, 32'h1);
        rd_check(A_CTRL, 32'h2, "ctrl_zero_len");

        // Early completion flags ERR
        mwr(A_LEN, 32'd4);
        run_dma(2, 0, 1'b0);

        // Register write during BUSY is dropped
        run_dma(4, 0, 1'b1);
        rd_check(A_ADDR, 32'h000100, "addr_busy_write");
        mwr(A_CTRL, 32'h2);
        rd_check(A_CTRL, ctrl_exp(), "ctrl_clear_done");

        // Stray SDRAM handshakes while idle change nothing
        @(posedge clk); #1;
        burst_data_req = 1'b1;
        exp_word.push_back(32'h0);
        @(posedge clk); #1;
        burst_data_req = 1'b0;
        burst_data_done = 1'b1;
        @(posedge clk); #1;
        burst_data_done = 1'b0;
        rd_check(A_CTRL, ctrl_exp(), "ctrl_stray_idle");
        rd_check(A_SENT, 32'(m_sent), "sent_stray_idle");

        // BUF_IDX wraps 255 -> 0
        mwr(A_IDX, 32'd255);
        mwr(A_DATA, $urandom);
        mwr(A_DATA, $urandom);
        rd_check(A_IDX, 32'd1, "idx_wrap");

        for (int it = 0; it < 20; it++) begin
            len = $urandom_range(1, 24);
            mwr(A_IDX, 32'h0);
            for (int i = 0; i < len; i++) mwr(A_DATA, $urandom);
            mwr(A_LEN, 32'(len));
            mwr(A_ADDR, $urandom);
            if ($urandom_range(0, 3) == 0) nr = $urandom_range(0, len - 1);
            else nr = len + $urandom_range(0, 2);
            mode = $urandom_range(0, 2);
            run_dma(nr, mode, 1'b0);
        end

        // LENGTH saturation, then reset in the middle of a burst
        mwr(A_LEN, 32'h1FF);
        rd_check(A_LEN, 32'd256, "len_saturate");
        mwr(A_IDX, 32'h0);
        for (int i = 0; i < 4; i++) mwr(A_DATA, $urandom);
        exp_baddr.push_back({m_addr, 1'b0});
        exp_blen.push_back(11'(m_len * 2));
        base = burst_cnt;
        reg_wr(A_CTRL, 32'h1);
        wait_burst(base, ok);
        if (ok) begin
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                burst_data_req = 1'b1;
                exp_word.push_back(m_buf[k]);
            end
        end
        @(posedge clk); #1;
        burst_data_req = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_burst_wr", 32'(burst_wr), 32'd0);
        check("midrst_burst_wdata", burst_wdata, 32'd0);
        check("midrst_burst_addr", 32'(burst_addr), 32'd0);
        check("midrst_burst_len", 32'(burst_len), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_len = 0; m_idx = 0; m_sent = 0; m_addr = '0; m_done = 1'b0; m_err = 1'b0;
        rd_check(A_CTRL, 32'h0, "midrst_ctrl");
        rd_check(A_LEN, 32'h0, "midrst_len");
        rd_check(A_ADDR, 32'h0, "midrst_addr");
        rd_check(A_IDX, 32'h0, "midrst_idx");
        rd_check(A_SENT, 32'h0, "midrst_sent");
        repeat (20) @(posedge clk);
        #1;

        // Recovery after reset
        mwr(A_IDX, 32'h0);
        for (int i = 0; i < 6; i++) mwr(A_DATA, $urandom);
        mwr(A_LEN, 32'd6);
        mwr(A_ADDR, 32'h00FFFFFF);
        run_dma(6, 0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("pending_bursts", 32'(exp_baddr.size()), 32'd0);
        check("pending_words", 32'(exp_word.size()), 32'd0);
        check("pending_reads", 32'(exp_rd.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
